// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between two masters, with bounded locked bursts.
// Zero-cycle grant; registered read response one cycle after a load; losers see ready=0 and must hold.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_we,
    input  logic [2:0]            req0_funct3,
    input  logic                  req0_lock,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_we,
    input  logic [2:0]            req1_funct3,
    input  logic                  req1_lock,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  locked,
    output logic                  lock_owner
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    // A locked transfer keeps the lock only while lock_cnt+1 < MAX_LOCK, i.e. lock_cnt < MAX_LOCK-1.
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_LOCK - 1);

    logic                  last_q, last_d;
    logic                  locked_q, locked_d;
    logic                  lock_owner_q, lock_owner_d;
    logic [CW-1:0]         lock_cnt_q, lock_cnt_d;
    logic                  resp0_valid_q, resp0_valid_d;
    logic                  resp1_valid_q, resp1_valid_d;
    logic [DATA_WIDTH-1:0] resp0_rdata_q, resp0_rdata_d;
    logic [DATA_WIDTH-1:0] resp1_rdata_q, resp1_rdata_d;

    logic sel;
    logic cand;
    logic grant;
    logic sel_we;
    logic sel_lock;

    always_comb begin
        sel  = 1'b0;
        cand = 1'b0;
        if (locked_q) begin
            sel  = lock_owner_q;
            cand = lock_owner_q ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            sel  = ~last_q;
            cand = 1'b1;
        end else if (req1_valid) begin
            sel  = 1'b1;
            cand = 1'b1;
        end else if (req0_valid) begin
            sel  = 1'b0;
            cand = 1'b1;
        end
    end

    // No grant can be issued while reset is asserted.
    assign grant      = cand && rst;
    assign req0_ready = grant && !sel;
    assign req1_ready = grant && sel;
    assign sel_we     = sel ? req1_we : req0_we;
    assign sel_lock   = sel ? req1_lock : req0_lock;

    assign mem_addr   = (grant && sel) ? req1_addr   : req0_addr;
    assign mem_wdata  = (grant && sel) ? req1_wdata  : req0_wdata;
    assign mem_funct3 = (grant && sel) ? req1_funct3 : req0_funct3;
    assign mem_we     = grant && sel_we;

    always_comb begin
        last_d        = last_q;
        locked_d      = locked_q;
        lock_owner_d  = lock_owner_q;
        lock_cnt_d    = lock_cnt_q;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        resp0_rdata_d = resp0_rdata_q;
        resp1_rdata_d = resp1_rdata_q;
        if (grant) begin
            last_d = sel;
            if (sel_lock && (lock_cnt_q < CNT_LIMIT)) begin
                locked_d     = 1'b1;
                lock_owner_d = sel;
                lock_cnt_d   = lock_cnt_q + CW'(1);
            end else begin
                locked_d   = 1'b0;
                lock_cnt_d = '0;
            end
            if (!sel_we) begin
                if (sel) begin
                    resp1_valid_d = 1'b1;
                    resp1_rdata_d = mem_rdata;
                end else begin
                    resp0_valid_d = 1'b1;
                    resp0_rdata_d = mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q        <= 1'b1;
            locked_q      <= 1'b0;
            lock_owner_q  <= 1'b0;
            lock_cnt_q    <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_rdata_q <= '0;
            resp1_rdata_q <= '0;
        end else begin
            last_q        <= last_d;
            locked_q      <= locked_d;
            lock_owner_q  <= lock_owner_d;
            lock_cnt_q    <= lock_cnt_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_rdata_q <= resp0_rdata_d;
            resp1_rdata_q <= resp1_rdata_d;
        end
    end

    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_rdata = resp0_rdata_q;
    assign resp1_rdata = resp1_rdata_q;
    assign locked      = locked_q;
    assign lock_owner  = lock_owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          v[2];
    logic          we[2];
    logic          lk[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wd[2];
    logic [2:0]    f3[2];

    logic          rdy0, rdy1, rv0, rv1, mem_we, locked, lock_owner;
    logic [DW-1:0] rd0, rd1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_f3;

    logic [DW-1:0] mem[64];
    logic [DW-1:0] ref_mem[64];
    assign mem_rdata = mem[mem_addr[7:2]];

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(rdy0), .req0_addr(addr[0]), .req0_wdata(wd[0]),
        .req0_we(we[0]), .req0_funct3(f3[0]), .req0_lock(lk[0]),
        .req1_valid(v[1]), .req1_ready(rdy1), .req1_addr(addr[1]), .req1_wdata(wd[1]),
        .req1_we(we[1]), .req1_funct3(f3[1]), .req1_lock(lk[1]),
        .resp0_valid(rv0), .resp0_rdata(rd0), .resp1_valid(rv1), .resp1_rdata(rd1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_funct3(mem_f3),
        .mem_rdata(mem_rdata), .locked(locked), .lock_owner(lock_owner)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int last_g;

    // Transaction-level model state
    int            m_last, m_owner, m_cnt;
    bit            m_locked;
    logic          m_rv[2];
    logic [DW-1:0] m_rd[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last   = 1;
        m_locked = 0;
        m_owner  = 0;
        m_cnt    = 0;
        m_rv[0]  = 1'b0;
        m_rv[1]  = 1'b0;
        m_rd[0]  = '0;
        m_rd[1]  = '0;
    endtask

    task automatic set_port(input int p, input logic vv, input logic w, input logic l,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        v[p] = vv; we[p] = w; lk[p] = l; addr[p] = a; wd[p] = d; f3[p] = 3'b010;
    endtask

    // One cycle: check at the falling edge, advance model, then commit memory writes after the rising edge.
    task automatic step();
        int            g;
        int            ga;
        logic          cw_we;
        logic [AW-1:0] cw_addr;
        logic [DW-1:0] cw_data;
        @(negedge clk);
        g = -1;
        if (rst) begin
            if (m_locked)          g = v[m_owner] ? m_owner : -1;
            else if (v[0] && v[1]) g = 1 - m_last;
            else if (v[0])         g = 0;
            else if (v[1])         g = 1;
        end
        ga = (g == 1) ? 1 : 0;
        chk("ready0", rdy0, g == 0);
        chk("ready1", rdy1, g == 1);
        chk("mem_we", mem_we, (g >= 0) ? we[ga] : 1'b0);
        chk("mem_addr", mem_addr, addr[ga]);
        if (g >= 0) begin
            chk("mem_wdata", mem_wdata, wd[ga]);
            chk("mem_funct3", mem_f3, f3[ga]);
        end
        chk("locked", locked, m_locked);
        if (m_locked) chk("lock_owner", lock_owner, m_owner);
        chk("resp0_valid", rv0, m_rv[0]);
        chk("resp1_valid", rv1, m_rv[1]);
        chk("resp0_rdata", rd0, m_rd[0]);
        chk("resp1_rdata", rd1, m_rd[1]);
        last_g = g;

        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (g >= 0) begin
            m_last = g;
            if (!we[ga]) begin
                m_rv[ga] = 1'b1;
                m_rd[ga] = ref_mem[addr[ga][7:2]];
            end else begin
                ref_mem[addr[ga][7:2]] = wd[ga];
            end
            if (lk[ga] && (m_cnt + 1 < ML)) begin
                m_locked = 1;
                m_owner  = g;
                m_cnt    = m_cnt + 1;
            end else begin
                m_locked = 0;
                m_cnt    = 0;
            end
        end
        if (!rst) model_reset();

        cw_we   = mem_we;
        cw_addr = mem_addr;
        cw_data = mem_wdata;
        @(posedge clk);
        #1;
        if (cw_we) mem[cw_addr[7:2]] = cw_data;
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_locked", locked, 1'b0);
        chk("arst_resp0_valid", rv0, 1'b0);
        chk("arst_resp1_valid", rv1, 1'b0);
        chk("arst_ready0", rdy0, 1'b0);
        chk("arst_mem_we", mem_we, 1'b0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        int exp_rr[4];
        int exp_lk[5];
        int exp_fr[6];
        exp_rr = '{0, 1, 0, 1};
        exp_lk = '{1, 1, 1, 1, 0};
        exp_fr = '{1, 1, 1, 1, 0, 1};

        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        set_port(0, 0, 0, 0, '0, '0);
        set_port(1, 0, 0, 0, '0, '0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("reset_locked", locked, 1'b0);
        chk("reset_resp0", rv0, 1'b0);
        chk("reset_rdata1", rd1, 32'h0);
        step();
        step();
        #2 rst = 1'b1;

        // Both ports reading, alternating grants starting with port 0
        set_port(0, 1, 0, 0, 32'h10, '0);
        set_port(1, 1, 0, 0, 32'h20, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_grant", last_g, exp_rr[i]);
            if (exp_rr[i] == 0) chk("rr_rdata0", rd0, mem[4]);
        end

        // Store then load-back on port 0
        set_port(1, 0, 0, 0, '0, '0);
        set_port(0, 1, 1, 0, 32'h40, 32'hDEADBEEF);
        step();
        set_port(0, 1, 0, 0, 32'h40, '0);
        step();
        chk("load_valid", rv0, 1'b1);
        chk("load_data", rd0, 32'hDEADBEEF);
        set_port(0, 0, 0, 0, '0, '0);
        step();

        // Port 1 locked burst of 3 then an unlocked transfer
        set_port(0, 1, 0, 0, 32'h04, '0);
        for (int i = 0; i < 5; i++) begin
            set_port(1, 1, i[0], (i < 3), 32'h80 + 32'(i * 4), 32'h1111_0000 + 32'(i));
            step();
            chk("lock_grant", last_g, exp_lk[i]);
        end

        // Port 1 holds lock permanently: forced release after MAX_LOCK transfers
        for (int i = 0; i < 6; i++) begin
            set_port(1, 1, 0, 1, 32'hC0, '0);
            step();
            chk("force_grant", last_g, exp_fr[i]);
            if (i == 3) chk("force_released", locked, 1'b0);
        end
        set_port(1, 1, 0, 0, 32'hC0, '0);
        step();

        // Lock owner goes idle mid-lock
        set_port(0, 0, 0, 0, 32'h08, '0);
        set_port(1, 1, 0, 1, 32'hC4, '0);
        step();
        set_port(0, 1, 0, 0, 32'h08, '0);
        set_port(1, 0, 0, 1, 32'hC4, '0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("idle_owner_grant", last_g, -1);
        end
        set_port(1, 1, 0, 0, 32'hC4, '0);
        step();
        chk("owner_resume", last_g, 1);

        // Reset mid-lock with a read response pending
        set_port(0, 0, 0, 0, 32'h08, '0);
        set_port(1, 1, 0, 1, 32'hC8, '0);
        step();
        chk("pre_reset_locked", locked, 1'b1);
        async_reset();
        set_port(0, 1, 0, 0, 32'h0C, '0);
        set_port(1, 1, 0, 0, 32'hCC, '0);
        step();
        chk("post_reset_tie", last_g, 0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            for (int p = 0; p < 2; p++) begin
                set_port(p, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                         ($urandom_range(0, 4) < 3), {24'h0, 6'($urandom_range(0, 15)), 2'b00},
                         $urandom);
                f3[p] = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 99) == 0) async_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the core load/store path (port 0) and a secondary master such as a program loader or DMA engine (port 1). It grants at most one access per cycle using round-robin priority, supports locked bursts with a bounded lock length, and returns read data through a registered, one-cycle response channel. It sits between the requesters and the data memory and drives the memory's address, write-data, write-enable and funct3 inputs.

## Interface
- DATA_WIDTH, 32, data width of both ports and of memory.
- ADDR_WIDTH, 32, address width.
- MAX_LOCK, 16, maximum consecutive locked transfers by one port before forced release (≥1).

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0_valid / req1_valid  input  1  port requests an access this cycle.
- req0_ready / req1_ready  output  1  access accepted this cycle (a transfer is valid&&ready).
- req0_addr / req1_addr  input  ADDR_WIDTH  byte address.
- req0_wdata / req1_wdata  input  DATA_WIDTH  store data.
- req0_we / req1_we  input  1  1 = store, 0 = load.
- req0_funct3 / req1_funct3  input  3  access width/sign code, passed to memory.
- req0_lock / req1_lock  input  1  keep grant after this transfer.
- resp0_valid / resp1_valid  output  1  read data valid.
- resp0_rdata / resp1_rdata  output  DATA_WIDTH  registered read data.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_we  output  1  memory write enable.
- mem_funct3  output  3  memory access width.
- mem_rdata  input  DATA_WIDTH  memory read data, combinational from mem_addr.
- locked  output  1  a lock is currently held.
- lock_owner  output  1  port holding the lock (valid when locked=1).

## Operation
- State: last (port served most recently), locked, lock_owner, lock_cnt (0..MAX_LOCK), resp pipeline registers.
- Unlocked selection: only one valid → that port; both valid → port ≠ last; none → no grant.
- Locked selection: only lock_owner may be granted; other port's ready=0 even if owner idle.
- ready_i = valid_i && (selected port == i); combinational from valid inputs and state.
- Memory outputs mux the selected port; no grant → mem_we=0, other mem outputs follow port 0 (don't-care).
- mem_we = selected port's we only on a transfer; never asserted without a transfer.
- On transfer by port p: last←p.
  - lock_p=1 and lock_cnt+1 < MAX_LOCK: locked←1, lock_owner←p, lock_cnt←lock_cnt+1.
  - lock_p=1 and lock_cnt+1 == MAX_LOCK: forced release — locked←0, lock_cnt←0; next cycle round-robin applies with last=p, so the other port wins a tie.
  - lock_p=0: locked←0, lock_cnt←0.
- Lock is never taken without a transfer; lock_cnt counts transfers, not cycles.
- Read transfer (we=0) by port p: next cycle resp_p_valid=1, resp_p_rdata=mem_rdata sampled at transfer edge. Otherwise resp_valid=0; resp_rdata holds last value.
- Store transfers produce no response.

## Timing
- Grant: zero-cycle (same-cycle ready). One transfer per cycle maximum; back-to-back transfers permitted every cycle.
- Read latency: resp_valid exactly 1 cycle after read transfer; pulse is 1 cycle, no backpressure.
- Reset (rst=0, asynchronous): last←1 (port 0 wins first tie), locked←0, lock_owner←0, lock_cnt←0, resp0/1_valid←0, resp0/1_rdata←0. While reset held: ready=0, mem_we=0.
- Reset mid-lock or with a response pending: lock dropped, pending response discarded.
- MAX_LOCK=1: lock never persists; every transfer releases.
- Request with lock while other port valid and unlocked: normal round-robin decides; lock only takes effect after winning.

## Test plan
- Reset, then both ports valid reads, addr 0x10/0x20 held -> ready0 cycle 1, ready1 cycle 2, alternating; resp0_rdata=mem[0x10] one cycle after each port-0 transfer.
- Port 0 only, store 0xDEADBEEF to 0x40, then load 0x40 -> mem_we=1 one cycle only, resp0_valid next cycle after load with 0xDEADBEEF.
- Port 1 lock=1 for 3 transfers then lock=0, port 0 valid throughout -> port 1 granted 4 consecutive transfers, req0_ready=0 until port 1's unlocked transfer, port 0 granted next.
- MAX_LOCK=4, port 1 lock held permanently, port 0 valid -> port 1 gets 4 transfers, then port 0 one, then port 1 again; locked drops on forced release.
- Lock owner drops valid mid-lock -> no grant, mem_we=0, req0_ready=0 until owner resumes.
- Assert rst low mid-lock with a read response pending -> locked=0, resp valids=0 immediately; after release, port 0 wins first tie.
